// File: rtl/qpsk_demod_ber.sv
// qpsk_demod_ber: hard-decision QPSK slicer with per-frame BER accounting.
//
// Noisy signed I/Q samples are sliced on their sign bits into a 2-bit decision {I,Q}.
// Each decision is compared against transmitted reference bits held in a small FIFO.
// Symbol, bit-error and (optionally) erasure counts are accumulated over one frame.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   start             one-cycle pulse that (re)starts a frame from any state
//   ref_valid/bits    reference bit push {I,Q}
//   rx_valid/real/imag  channel sample, signed BI-bit I and Q
//   rx_bits(_valid)   sliced decision and its one-cycle valid pulse
//   rx_erase          decision was an erasure (0 unless ERASURE_EN)
//   sym/err/erase_count  saturating frame counters
//   busy, done        state is RUN / frame complete
//   ovf, unf          sticky FIFO overflow / underflow flags
//
// Build option: define ERASURE_EN to enable erasure detection (|sample| < ERASE_THR).
module qpsk_demod_ber #(
  parameter int unsigned BI         = 7,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FRAME_SYMS = 320000,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned ERASE_THR  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 ref_valid,
  input  logic [1:0]           ref_bits,
  input  logic                 rx_valid,
  input  logic signed [BI-1:0] rx_real,
  input  logic signed [BI-1:0] rx_imag,
  output logic [1:0]           rx_bits,
  output logic                 rx_bits_valid,
  output logic                 rx_erase,
  output logic [CNT_W-1:0]     sym_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     erase_count,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic                 unf
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DepthC = (PW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FrameC = CNT_W'(FRAME_SYMS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop;

  logic             s1_valid_q, s1_valid_d, s1_counted_q, s1_counted_d;
  logic [1:0]       s1_bits_q, s1_bits_d, s1_ref_q, s1_ref_d;

  logic [1:0]       rx_bits_q, rx_bits_d;
  logic             rx_bits_valid_q, rx_bits_valid_d;
  logic [CNT_W-1:0] sym_q, sym_d, err_q, err_d;
  logic [1:0]       diff, n_err;

`ifdef ERASURE_EN
  localparam logic [BI-1:0] ThrC = BI'(ERASE_THR);

  logic             s1_erase_q, s1_erase_d, rx_erase_q, rx_erase_d;
  logic [CNT_W-1:0] erase_q, erase_d;

  // Most-negative code has no positive twin; clamp it to the largest positive magnitude.
  function automatic logic below_thr(logic [BI-1:0] v);
    logic [BI-1:0] mag;
    if (!v[BI-1])                             mag = v;
    else if (v == {1'b1, {(BI-1){1'b0}}})     mag = {1'b0, {(BI-1){1'b1}}};
    else                                      mag = ~v + 1'b1;
    return mag < ThrC;
  endfunction
`else
  logic unused_samples;
  assign unused_samples = ^{rx_real[BI-2:0], rx_imag[BI-2:0]};
`endif

  function automatic logic [CNT_W-1:0] sat_add(logic [CNT_W-1:0] a, logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    cnt_d           = cnt_q;
    full_d          = full_q;
    empty_d         = empty_q;
    ovf_d           = ovf_q;
    unf_d           = unf_q;
    s1_valid_d      = s1_valid_q;
    s1_counted_d    = s1_counted_q;
    s1_bits_d       = s1_bits_q;
    s1_ref_d        = s1_ref_q;
    rx_bits_d       = rx_bits_q;
    rx_bits_valid_d = 1'b0;
    sym_d           = sym_q;
    err_d           = err_q;
    push            = 1'b0;
    pop             = 1'b0;
    diff            = s1_bits_q ^ s1_ref_q;
    n_err           = {1'b0, diff[1]} + {1'b0, diff[0]};
`ifdef ERASURE_EN
    s1_erase_d      = s1_erase_q;
    rx_erase_d      = 1'b0;
    erase_d         = erase_q;
`endif

    if (start) begin
      // Restart from any state: pipeline and FIFO contents are dropped.
      state_d      = StRun;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      cnt_d        = '0;
      full_d       = 1'b0;
      empty_d      = 1'b1;
      ovf_d        = 1'b0;
      unf_d        = 1'b0;
      s1_valid_d   = 1'b0;
      s1_counted_d = 1'b0;
      sym_d        = '0;
      err_d        = '0;
`ifdef ERASURE_EN
      erase_d      = '0;
`endif
    end else if (state_q == StRun) begin
      // Stage 2: publish the decision and update the counters.
      if (s1_valid_q) begin
        rx_bits_valid_d = 1'b1;
        rx_bits_d       = s1_bits_q;
`ifdef ERASURE_EN
        rx_erase_d      = s1_erase_q;
`endif
        if (s1_counted_q) begin
          sym_d = sat_add(sym_q, 2'd1);
`ifdef ERASURE_EN
          if (s1_erase_q) erase_d = sat_add(erase_q, 2'd1);
          else            err_d   = sat_add(err_q, n_err);
`else
          err_d = sat_add(err_q, n_err);
`endif
          if (sym_d == FrameC) state_d = StDone;
        end
      end

      // Stage 1: slice the sample and pop its reference. Pushes never bypass to the pop.
      pop  = rx_valid && !empty_q;
      push = ref_valid && (!full_q || pop);
      if (ref_valid && !push)  ovf_d = 1'b1;
      if (rx_valid && empty_q) unf_d = 1'b1;

      s1_valid_d   = rx_valid;
      s1_counted_d = pop;
      s1_bits_d    = {rx_real[BI-1], rx_imag[BI-1]};
      s1_ref_d     = mem_q[rd_ptr_q];
`ifdef ERASURE_EN
      s1_erase_d   = below_thr(rx_real) || below_thr(rx_imag);
`endif

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      full_d  = (cnt_d == DepthC);
      empty_d = (cnt_d == '0);
    end else begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
      full_q          <= 1'b0;
      empty_q         <= 1'b1;
      ovf_q           <= 1'b0;
      unf_q           <= 1'b0;
      s1_valid_q      <= 1'b0;
      s1_counted_q    <= 1'b0;
      s1_bits_q       <= '0;
      s1_ref_q        <= '0;
      rx_bits_q       <= '0;
      rx_bits_valid_q <= 1'b0;
      sym_q           <= '0;
      err_q           <= '0;
`ifdef ERASURE_EN
      s1_erase_q      <= 1'b0;
      rx_erase_q      <= 1'b0;
      erase_q         <= '0;
`endif
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
      full_q          <= full_d;
      empty_q         <= empty_d;
      ovf_q           <= ovf_d;
      unf_q           <= unf_d;
      s1_valid_q      <= s1_valid_d;
      s1_counted_q    <= s1_counted_d;
      s1_bits_q       <= s1_bits_d;
      s1_ref_q        <= s1_ref_d;
      rx_bits_q       <= rx_bits_d;
      rx_bits_valid_q <= rx_bits_valid_d;
      sym_q           <= sym_d;
      err_q           <= err_d;
`ifdef ERASURE_EN
      s1_erase_q      <= s1_erase_d;
      rx_erase_q      <= rx_erase_d;
      erase_q         <= erase_d;
`endif
    end
  end

  // Storage needs no reset: the pointers and flags define what is valid.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= ref_bits;
  end

  assign rx_bits       = rx_bits_q;
  assign rx_bits_valid = rx_bits_valid_q;
  assign sym_count     = sym_q;
  assign err_count     = err_q;
  assign busy          = (state_q == StRun);
  assign done          = (state_q == StDone);
  assign ovf           = ovf_q;
  assign unf           = unf_q;
`ifdef ERASURE_EN
  assign rx_erase      = rx_erase_q;
  assign erase_count   = erase_q;
`else
  assign rx_erase      = 1'b0;
  assign erase_count   = '0;
`endif

endmodule

// File: tb/tb_qpsk_demod_ber.sv
// Self-checking bench for qpsk_demod_ber with a queue-based reference model.
// Small frame and counter widths are used so frame end and saturation are reachable.
module tb_qpsk_demod_ber;
  localparam int BI    = 7;
  localparam int DEPTH = 16;
  localparam int FRAME = 20;
  localparam int CW    = 5;
  localparam int THR   = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic                 ref_valid = 1'b0;
  logic [1:0]           ref_bits = 2'b00;
  logic                 rx_valid = 1'b0;
  logic signed [BI-1:0] rx_real = '0;
  logic signed [BI-1:0] rx_imag = '0;
  logic [1:0]           rx_bits;
  logic                 rx_bits_valid, rx_erase, busy, done, ovf, unf;
  logic [CW-1:0]        sym_count, err_count, erase_count;

  always #5 clk = ~clk;

  qpsk_demod_ber #(
    .BI(BI), .FIFO_DEPTH(DEPTH), .FRAME_SYMS(FRAME), .CNT_W(CW), .ERASE_THR(THR)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ref_valid(ref_valid), .ref_bits(ref_bits),
    .rx_valid(rx_valid), .rx_real(rx_real), .rx_imag(rx_imag), .rx_bits(rx_bits),
    .rx_bits_valid(rx_bits_valid), .rx_erase(rx_erase), .sym_count(sym_count),
    .err_count(err_count), .erase_count(erase_count), .busy(busy), .done(done),
    .ovf(ovf), .unf(unf)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: 0 idle, 1 run, 2 done.
  int         m_state = 0;
  logic [1:0] refq[$];
  bit         p_valid, p_counted, p_erase;
  logic [1:0] p_bits, p_ref;
  logic [1:0] e_bits;
  bit         e_valid, e_erase, e_ovf, e_unf;
  int         e_sym, e_err, e_era;

  function automatic int mag(int v);
    if (v >= 0) return v;
    if (v == -(1 << (BI-1))) return (1 << (BI-1)) - 1;
    return -v;
  endfunction

  function automatic int sat(int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  function automatic int sv(bit b);
    return b ? -20 : 20;
  endfunction

  // Drive one cycle of inputs, advance the model, then sample just after the edge.
  task automatic step(input bit rst, input bit st, input bit rv, input logic [1:0] rb,
                      input bit xv, input int re, input int im);
    bit         n_valid, n_counted, n_erase;
    logic [1:0] n_bits, n_ref;
    reset = rst; start = st; ref_valid = rv; ref_bits = rb;
    rx_valid = xv; rx_real = BI'(re); rx_imag = BI'(im);
    if (!rst) begin
      m_state = 0; refq.delete(); p_valid = 0; p_counted = 0; p_erase = 0;
      e_bits = 2'b00; e_valid = 0; e_erase = 0; e_ovf = 0; e_unf = 0;
      e_sym = 0; e_err = 0; e_era = 0;
    end else if (st) begin
      m_state = 1; refq.delete(); p_valid = 0; e_valid = 0; e_erase = 0;
      e_ovf = 0; e_unf = 0; e_sym = 0; e_err = 0; e_era = 0;
    end else if (m_state == 1) begin
      e_valid = p_valid;
      e_erase = 0;
      if (p_valid) begin
        e_bits  = p_bits;
        e_erase = p_erase;
        if (p_counted) begin
          e_sym = sat(e_sym + 1);
          if (p_erase) e_era = sat(e_era + 1);
          else e_err = sat(e_err + int'(p_bits[1] != p_ref[1]) + int'(p_bits[0] != p_ref[0]));
          if (e_sym == FRAME) m_state = 2;
        end
      end
      n_valid = xv; n_counted = 0; n_erase = 0; n_bits = 2'b00; n_ref = 2'b00;
      if (xv) begin
        n_bits = {re < 0, im < 0};
`ifdef ERASURE_EN
        n_erase = (mag(re) < THR) || (mag(im) < THR);
`endif
        if (refq.size() > 0) begin
          n_counted = 1;
          n_ref = refq.pop_front();
        end else begin
          e_unf = 1;
        end
      end
      if (rv) begin
        if (refq.size() < DEPTH) refq.push_back(rb);
        else e_ovf = 1;
      end
      p_valid = n_valid; p_counted = n_counted; p_erase = n_erase;
      p_bits = n_bits; p_ref = n_ref;
    end else begin
      e_valid = 0; e_erase = 0; p_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 1, 1, 2'b11, 1, -20, -20);
    n_chk++;
    if ({rx_bits, rx_bits_valid, rx_erase, sym_count, err_count, erase_count,
         busy, done, ovf, unf} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got bits=%b v=%b sym=%0d err=%0d busy=%b done=%b ovf=%b unf=%b exp all zero",
               rx_bits, rx_bits_valid, sym_count, err_count, busy, done, ovf, unf);
    end
    step(1, 0, 0, 2'b00, 0, 0, 0);
    step(1, 1, 0, 2'b00, 0, 0, 0);
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL start_busy got busy=%b done=%b exp busy=1 done=0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [1:0] expb [4];
    int         sr [4];
    int         si [4];
    expb = '{2'b00, 2'b01, 2'b10, 2'b11};
    sr = '{20, 20, -20, -20};
    si = '{20, -20, 20, -20};
    step(1, 1, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, expb[i], 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(1, 0, 0, 2'b00, 1, sr[i], si[i]);
      else step(1, 0, 0, 2'b00, 0, 0, 0);
      n_chk++;
      if (i >= 1 && i <= 4) begin
        if (rx_bits_valid !== 1'b1 || rx_bits !== expb[i-1]) begin
          n_err++;
          $display("FAIL basic_slice idx=%0d got v=%b bits=%b exp v=1 bits=%b",
                   i-1, rx_bits_valid, rx_bits, expb[i-1]);
        end
      end else if (rx_bits_valid !== 1'b0) begin
        n_err++;
        $display("FAIL basic_latency step=%0d got v=%b exp v=0", i, rx_bits_valid);
      end
    end
    n_chk++;
    if (sym_count !== CW'(4) || err_count !== CW'(0) || unf !== 1'b0) begin
      n_err++;
      $display("FAIL basic_counts got sym=%0d err=%0d unf=%b exp sym=4 err=0 unf=0",
               sym_count, err_count, unf);
    end
  endtask

  task automatic test_errors();
    step(1, 1, 0, 2'b00, 0, 0, 0);
    step(1, 0, 1, 2'b00, 0, 0, 0);
    step(1, 0, 1, 2'b11, 0, 0, 0);
    step(1, 0, 0, 2'b00, 1, -5, -30);
    step(1, 0, 0, 2'b00, 1, 0, -1);
    n_chk++;
    if (err_count !== CW'(2) || rx_bits !== 2'b11) begin
      n_err++;
      $display("FAIL err_two got err=%0d bits=%b exp err=2 bits=11", err_count, rx_bits);
    end
    step(1, 0, 0, 2'b00, 0, 0, 0);
    n_chk++;
    if (rx_bits !== 2'b01 || err_count !== CW'(e_err) || sym_count !== CW'(2)) begin
      n_err++;
      $display("FAIL err_zero_slice got bits=%b err=%0d sym=%0d exp bits=01 err=%0d sym=2",
               rx_bits, err_count, sym_count, e_err);
    end
`ifndef ERASURE_EN
    n_chk++;
    if (err_count !== CW'(3)) begin
      n_err++;
      $display("FAIL err_total got err=%0d exp 3", err_count);
    end
`endif
  endtask

  task automatic test_erasure();
    step(1, 1, 0, 2'b00, 0, 0, 0);
    step(1, 0, 1, 2'b11, 0, 0, 0);
    step(1, 0, 0, 2'b00, 1, 3, 40);
    step(1, 0, 0, 2'b00, 0, 0, 0);
`ifdef ERASURE_EN
    n_chk++;
    if (rx_bits_valid !== 1'b1 || rx_erase !== 1'b1) begin
      n_err++;
      $display("FAIL erase_flag got v=%b erase=%b exp v=1 erase=1", rx_bits_valid, rx_erase);
    end
    n_chk++;
    if (erase_count !== CW'(1) || err_count !== CW'(0) || sym_count !== CW'(1)) begin
      n_err++;
      $display("FAIL erase_counts got era=%0d err=%0d sym=%0d exp era=1 err=0 sym=1",
               erase_count, err_count, sym_count);
    end
`else
    n_chk++;
    if (rx_erase !== 1'b0 || erase_count !== CW'(0) || err_count !== CW'(2) ||
        sym_count !== CW'(1)) begin
      n_err++;
      $display("FAIL no_erase got erase=%b era=%0d err=%0d sym=%0d exp erase=0 era=0 err=2 sym=1",
               rx_erase, erase_count, err_count, sym_count);
    end
`endif
  endtask

  task automatic test_frame_done();
    logic [1:0] r;
    step(1, 1, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < FRAME + 2; k++) begin
      r = 2'($urandom_range(3));
      step(1, 0, 1, r, 0, 0, 0);
      n_chk++;
      if (done !== (sym_count == CW'(FRAME)) || sym_count !== CW'(e_sym)) begin
        n_err++;
        $display("FAIL frame_progress k=%0d got sym=%0d done=%b exp sym=%0d done=%b",
                 k, sym_count, done, e_sym, m_state == 2);
      end
      step(1, 0, 0, 2'b00, 1, sv(r[1]), sv(r[0]));
    end
    step(1, 0, 0, 2'b00, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    n_chk++;
    if (sym_count !== CW'(FRAME) || done !== 1'b1 || busy !== 1'b0 || err_count !== CW'(0)) begin
      n_err++;
      $display("FAIL frame_end got sym=%0d done=%b busy=%b err=%0d exp sym=%0d done=1 busy=0 err=0",
               sym_count, done, busy, err_count, FRAME);
    end
  endtask

  task automatic test_saturate();
    step(1, 1, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < FRAME; k++) begin
      step(1, 0, 1, 2'b00, 0, 0, 0);
      step(1, 0, 0, 2'b00, 1, -20, -20);
    end
    step(1, 0, 0, 2'b00, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    n_chk++;
    if (err_count !== CW'(MAXC) || err_count !== CW'(e_err) || done !== 1'b1) begin
      n_err++;
      $display("FAIL err_saturate got err=%0d done=%b exp err=%0d done=1", err_count, done, MAXC);
    end
  endtask

  task automatic test_fifo();
    step(1, 1, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) step(1, 0, 1, 2'b01, 0, 0, 0);
    n_chk++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL fifo_fill_no_ovf got ovf=%b exp 0", ovf);
    end
    step(1, 0, 1, 2'b01, 1, 20, -20);
    n_chk++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL fifo_push_pop_full got ovf=%b exp 0", ovf);
    end
    step(1, 0, 1, 2'b01, 0, 0, 0);
    n_chk++;
    if (ovf !== 1'b1 || unf !== 1'b0) begin
      n_err++;
      $display("FAIL fifo_ovf got ovf=%b unf=%b exp ovf=1 unf=0", ovf, unf);
    end
    for (int k = 0; k < DEPTH; k++) step(1, 0, 0, 2'b00, 1, 20, -20);
    n_chk++;
    if (unf !== 1'b0) begin
      n_err++;
      $display("FAIL fifo_occupancy got unf=%b after %0d pops exp 0", unf, DEPTH);
    end
    step(1, 0, 0, 2'b00, 1, -20, 20);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    n_chk++;
    if (unf !== 1'b1 || sym_count !== CW'(DEPTH + 1) || err_count !== CW'(0) ||
        rx_bits !== 2'b10) begin
      n_err++;
      $display("FAIL fifo_unf got unf=%b sym=%0d err=%0d bits=%b exp unf=1 sym=%0d err=0 bits=10",
               unf, sym_count, err_count, rx_bits, DEPTH + 1);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(1, 0, 1, 2'b11, 0, 0, 0);
    step(1, 0, 0, 2'b00, 1, 20, 20);
    step(1, 0, 0, 2'b00, 1, 20, 20);
    step(0, 0, 0, 2'b00, 0, 0, 0);
    n_chk++;
    if ({rx_bits, rx_bits_valid, rx_erase, sym_count, err_count, erase_count,
         busy, done, ovf, unf} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs got bits=%b v=%b sym=%0d err=%0d busy=%b done=%b exp all zero",
               rx_bits, rx_bits_valid, sym_count, err_count, busy, done);
    end
    step(1, 0, 0, 2'b00, 0, 0, 0);
    step(1, 1, 0, 2'b00, 0, 0, 0);
    step(1, 0, 1, 2'b00, 0, 0, 0);
    step(1, 0, 0, 2'b00, 1, 20, 20);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0);
    n_chk++;
    if (sym_count !== CW'(1) || err_count !== CW'(0) || unf !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_restart got sym=%0d err=%0d unf=%b busy=%b exp sym=1 err=0 unf=0 busy=1",
               sym_count, err_count, unf, busy);
    end
  endtask

  task automatic test_random();
    bit st, rst, rv, xv;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(199) != 0);
      st  = (m_state != 1) ? ($urandom_range(3) == 0) : ($urandom_range(149) == 0);
      rv  = ($urandom_range(1) == 1);
      xv  = ($urandom_range(1) == 1);
      step(rst, st, rv, 2'($urandom_range(3)), xv,
           int'($urandom_range(127)) - 64, int'($urandom_range(127)) - 64);
      n_chk++;
      if (rx_bits !== e_bits || rx_bits_valid !== e_valid || rx_erase !== e_erase ||
          sym_count !== CW'(e_sym) || err_count !== CW'(e_err) || erase_count !== CW'(e_era) ||
          busy !== (m_state == 1) || done !== (m_state == 2) || ovf !== e_ovf || unf !== e_unf) begin
        n_err++;
        $display("FAIL random cyc=%0d got bits=%b v=%b er=%b sym=%0d err=%0d era=%0d busy=%b done=%b ovf=%b unf=%b exp bits=%b v=%b er=%b sym=%0d err=%0d era=%0d busy=%b done=%b ovf=%b unf=%b",
                 c, rx_bits, rx_bits_valid, rx_erase, sym_count, err_count, erase_count,
                 busy, done, ovf, unf, e_bits, e_valid, e_erase, e_sym, e_err, e_era,
                 m_state == 1, m_state == 2, e_ovf, e_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_erasure();
    test_frame_done();
    test_saturate();
    test_fifo();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
